multi_fm_ctrl: RTL and testbench
================================

MULTI_FM_CTRL -- requirements
Module: multi_fm_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHIPS, default 2, number of FM chips driven (legal range 1..4).
REQ-002 SHALL have parameter SETUP_CYC, default 2, fclk cycles from chip select to strobe (legal range >=1).
REQ-003 SHALL have parameter PULSE_CYC, default 4, fclk cycles of rd_n/wr_n low (legal range >=1).
REQ-004 SHALL have parameter HOLD_CYC, default 2, fclk cycles of chip select held after strobe (legal range >=1).
REQ-005 SHALL have ports: fclk  in  1  single clock; rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: req_valid  in  1  bus request; req_ready  out  1  request accepted when high with req_valid; req_we  in  1  1=write 0=read; req_a0  in  1  address/data select; req_wdata  in  8  write data.
REQ-007 SHALL have ports: rd_data  out  8  read result; rd_valid  out  1  one-cycle read-done pulse.
REQ-008 SHALL have ports: cfg_wr  in  1  config strobe; cfg_d  in  8  config byte.
REQ-009 SHALL have ports: cs_n  out  NUM_CHIPS  per-chip select; rd_n  out  1; wr_n  out  1; a0  out  1; d_out  out  8; d_oe  out  1  local bus drive enable; d_in  in  8  local bus read data; dac_en  out  1  FM DAC gate.

Function
REQ-010 SHALL hold config register: cfg_d[1:0] chip index, [2] status mode, [3] DAC enable, [4] broadcast; loaded on cfg_wr in the next cycle.
REQ-011 SHALL ignore (keep previous index) a cfg_wr whose chip index >= NUM_CHIPS; other bits still load.
REQ-012 SHALL run FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE; req_ready = (state==IDLE).
REQ-013 SHALL on accept (req_valid & req_ready) capture we, a0, wdata, chip index, status mode; a0 driven = captured a0, forced 0 for reads when status mode set.
REQ-014 SHALL in SETUP assert selected cs_n low, a0 and d_out valid, d_oe=we, for SETUP_CYC cycles.
REQ-015 SHALL in STROBE additionally drive wr_n (write) or rd_n (read) low for PULSE_CYC cycles.
REQ-016 SHALL sample d_in into rd_data on the last STROBE cycle of a read; rd_valid high for exactly the first HOLD cycle.
REQ-017 SHALL in HOLD keep cs_n, a0, d_out, d_oe, strobes high, for HOLD_CYC cycles; req_ready rises the cycle after last HOLD cycle.
REQ-018 SHALL never assert rd_n and wr_n together; cs_n all high in IDLE.
REQ-019 SHALL apply cfg_wr during a transaction to the register immediately but not to the transaction in flight (captured values used).
REQ-020 SHALL, on cfg_wr and req accept in the same cycle, use the old config for that request.
REQ-021 SHALL drive dac_en = config bit 3 directly from the register.

Reset
REQ-022 SHALL on rst_n low at an fclk edge: FSM IDLE, cs_n all ones, rd_n=1, wr_n=1, a0=0, d_out=0, d_oe=0, rd_data=0, rd_valid=0, config=0 (chip 0, DAC off).
REQ-023 SHALL abort a transaction in progress on reset with all strobes deasserted by the next edge; no rd_valid issued.

Configuration
REQ-024 SHALL with MULTI_FM_BROADCAST_EN defined: writes captured with broadcast bit set assert all NUM_CHIPS cs_n together; reads always use the single indexed chip.
REQ-025 SHALL without MULTI_FM_BROADCAST_EN: broadcast bit stored but ignored; only the indexed chip is selected.

Structure
REQ-026 SHALL place FSM state enum, config bit positions and NUM_CHIPS limits in shared package multi_fm_pkg.
REQ-027 SHALL use one sub-module, fm_cycle_timer, a down-counter loaded per phase and signalling phase end.

Verification (NUM_CHIPS=2, SETUP=2, PULSE=4, HOLD=2)
REQ-028 SHALL cover: cfg 0x01, write a0=1 data 0x5A -> cs_n=2'b01 for 8 cycles, wr_n low cycles 3..6, d_oe=1, req_ready low 8 cycles.
REQ-029 SHALL cover: cfg 0x04, read a0=1, d_in=0xC3 -> a0=0, rd_n low 4 cycles, rd_data=0xC3, single rd_valid pulse.
REQ-030 SHALL cover: cfg 0x03 after cfg 0x01 -> index stays 1; cfg 0x08 -> dac_en=1.
REQ-031 SHALL cover: cfg_wr 0x00 mid-write to chip 1 -> transaction completes on chip 1; next request uses chip 0.
REQ-032 SHALL cover: rst_n low during STROBE -> next edge cs_n=2'b11, rd_n=wr_n=1, rd_valid never high.
REQ-033 SHALL cover, MULTI_FM_BROADCAST_EN defined: cfg 0x10, write -> cs_n=2'b00; read -> cs_n=2'b10.

Source files
------------

// File: rtl/multi_fm_pkg.sv
// multi_fm_pkg
//   Shared definitions for the multi-chip FM bus controller: the bus cycle
//   state encoding, the layout of the configuration byte, chip-count limits
//   and the timer width used by fm_cycle_timer.
//   No ports (package).

package multi_fm_pkg;

  // Chip-count limits supported by the 2-bit chip index field.
  localparam int MIN_CHIPS = 1;
  localparam int MAX_CHIPS = 4;

  // Width of the phase down-counter; phases up to 65536 cycles long.
  localparam int TIMER_W = 16;

  // Bit positions inside the configuration byte.
  localparam int CFG_IDX_LSB    = 0;
  localparam int CFG_IDX_MSB    = 1;
  localparam int CFG_STATUS_BIT = 2;
  localparam int CFG_DAC_BIT    = 3;
  localparam int CFG_BCAST_BIT  = 4;

  // Bus cycle phases.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } fm_state_t;

  // Stored configuration register.
  typedef struct packed {
    logic       bcast;
    logic       dac;
    logic       status;
    logic [1:0] idx;
  } fm_cfg_t;

  // True when a requested chip index addresses a fitted chip.
  function automatic logic idx_in_range(input logic [1:0] idx, input int num_chips);
    return (int'({30'b0, idx}) < num_chips);
  endfunction

endpackage

// File: rtl/multi_fm_ctrl_timer.sv
// fm_cycle_timer
//   Down-counter that times one bus phase. The controller loads it with
//   (phase length - 1) when a phase starts; done is high during the last
//   cycle of the phase (count reached zero).
//   Ports:
//     clk      in   clock
//     rst_n    in   synchronous active-low reset
//     load     in   load load_val this cycle
//     load_val in   TIMER_W bits, phase length minus one
//     done     out  current phase is in its final cycle

module fm_cycle_timer
  import multi_fm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Count down to zero and park there until the next phase reloads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/multi_fm_ctrl.sv
// multi_fm_ctrl
//   Bus controller driving up to four FM synthesis chips over a shared
//   8-bit local bus. Each request runs SETUP (chip select, address, data),
//   STROBE (rd_n or wr_n low) and HOLD (select kept, strobes released).
//   Build option: define MULTI_FM_BROADCAST_EN to let writes captured with
//   the broadcast bit select every chip at once.
//   Ports:
//     fclk, rst_n                   clock, synchronous active-low reset
//     req_valid/req_ready           request handshake (ready = idle)
//     req_we, req_a0, req_wdata     request direction, address select, data
//     rd_data, rd_valid             read result and one-cycle done pulse
//     cfg_wr, cfg_d                 configuration byte write
//     cs_n[NUM_CHIPS], rd_n, wr_n   chip selects and strobes
//     a0, d_out, d_oe, d_in         chip address select and data bus
//     dac_en                        FM DAC gate from the config register

module multi_fm_ctrl
  import multi_fm_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_a0,
  input  logic [7:0]           req_wdata,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  input  logic                 cfg_wr,
  input  logic [7:0]           cfg_d,
  output logic [NUM_CHIPS-1:0] cs_n,
  output logic                 rd_n,
  output logic                 wr_n,
  output logic                 a0,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  input  logic [7:0]           d_in,
  output logic                 dac_en
);

  fm_state_t          state;
  fm_cfg_t            cfg_q;
  logic               cap_we;
  logic               accept;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_done;
  logic [NUM_CHIPS-1:0] idx_mask;
  logic [NUM_CHIPS-1:0] cs_sel;
  logic               unused_cfg_bits;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign dac_en    = cfg_q.dac;

  // One-hot mask of the chip currently named by the config register.
  always_comb begin
    idx_mask = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (cfg_q.idx == 2'(i)) begin
        idx_mask[i] = 1'b1;
      end
    end
  end

  // Chips to select for a request arriving now; reads never broadcast.
`ifdef MULTI_FM_BROADCAST_EN
  always_comb begin
    cs_sel = idx_mask;
    if (req_we && cfg_q.bcast) begin
      cs_sel = '1;
    end
  end
  assign unused_cfg_bits = ^cfg_d[7:5];
`else
  assign cs_sel          = idx_mask;
  assign unused_cfg_bits = ^{cfg_d[7:5], cfg_q.bcast};
`endif

  // Phase timer reload: each phase loads its own length as it begins.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(PULSE_CYC - 1);
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(HOLD_CYC - 1);
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  fm_cycle_timer u_timer (
    .clk      (fclk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Config register plus the bus FSM. All pin outputs are registered and
  // latched at accept time, so a config write during a transaction only
  // affects later requests. A config write in the accept cycle is seen by
  // the next request because the FSM reads cfg_q before it updates.
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cfg_q    <= '0;
      cap_we   <= 1'b0;
      cs_n     <= '1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      a0       <= 1'b0;
      d_out    <= '0;
      d_oe     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;

      if (cfg_wr) begin
        cfg_q.status <= cfg_d[CFG_STATUS_BIT];
        cfg_q.dac    <= cfg_d[CFG_DAC_BIT];
        cfg_q.bcast  <= cfg_d[CFG_BCAST_BIT];
        if (idx_in_range(cfg_d[CFG_IDX_MSB:CFG_IDX_LSB], NUM_CHIPS)) begin
          cfg_q.idx <= cfg_d[CFG_IDX_MSB:CFG_IDX_LSB];
        end
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_SETUP;
            cap_we <= req_we;
            cs_n   <= ~cs_sel;
            a0     <= (!req_we && cfg_q.status) ? 1'b0 : req_a0;
            d_out  <= req_wdata;
            d_oe   <= req_we;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state <= ST_STROBE;
            if (cap_we) begin
              wr_n <= 1'b0;
            end else begin
              rd_n <= 1'b0;
            end
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            state <= ST_HOLD;
            wr_n  <= 1'b1;
            rd_n  <= 1'b1;
            if (!cap_we) begin
              rd_data  <= d_in;
              rd_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            state <= ST_IDLE;
            cs_n  <= '1;
            a0    <= 1'b0;
            d_out <= '0;
            d_oe  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_fm_ctrl.sv
// tb_multi_fm_ctrl
//   Self-checking bench for multi_fm_ctrl at NUM_CHIPS=2, SETUP=2, PULSE=4,
//   HOLD=2. Expected pin waveforms come from a transaction-level model: a
//   config record updated by the register rules, and a per-cycle timeline
//   derived from the phase lengths. Honours MULTI_FM_BROADCAST_EN.

module tb_multi_fm_ctrl;

  localparam int N = 2;
  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 2;
  localparam int T = S + P + H;

`ifdef MULTI_FM_BROADCAST_EN
  localparam bit BCAST_BUILD = 1'b1;
`else
  localparam bit BCAST_BUILD = 1'b0;
`endif

  logic         fclk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic         req_a0;
  logic [7:0]   req_wdata;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic         cfg_wr;
  logic [7:0]   cfg_d;
  logic [N-1:0] cs_n;
  logic         rd_n;
  logic         wr_n;
  logic         a0;
  logic [7:0]   d_out;
  logic         d_oe;
  logic [7:0]   d_in;
  logic         dac_en;

  int vectors;
  int miscompares;

  // Reference config record.
  int m_idx;
  bit m_status;
  bit m_dac;
  bit m_bcast;

  multi_fm_ctrl #(
    .NUM_CHIPS (N),
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .HOLD_CYC  (H)
  ) dut (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_a0    (req_a0),
    .req_wdata (req_wdata),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .cfg_wr    (cfg_wr),
    .cfg_d     (cfg_d),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .a0        (a0),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .d_in      (d_in),
    .dac_en    (dac_en)
  );

  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  function automatic void model_reset();
    m_idx    = 0;
    m_status = 1'b0;
    m_dac    = 1'b0;
    m_bcast  = 1'b0;
  endfunction

  function automatic void model_cfg(input logic [7:0] d);
    int idx;
    idx = d % 4;
    if (idx < N) m_idx = idx;
    m_status = d[2];
    m_dac    = d[3];
    m_bcast  = d[4];
  endfunction

  // Active-low select pattern a request issued now should produce.
  function automatic logic [N-1:0] model_cs(input bit we);
    logic [N-1:0] m;
    m = '1;
    m[m_idx] = 1'b0;
    if (BCAST_BUILD && we && m_bcast) m = '0;
    return m;
  endfunction

  task automatic write_cfg(input logic [7:0] d);
    cfg_wr = 1'b1;
    cfg_d  = d;
    @(posedge fclk); #1;
    cfg_wr = 1'b0;
    model_cfg(d);
    vectors++;
    if (dac_en !== m_dac)
      $display("[TB] FAIL dac_en after cfg %h: got %b expected %b", d, dac_en, m_dac);
    if (dac_en !== m_dac) miscompares++;
  endtask

  // Runs one full transaction, optionally writing config at cycle mid_cyc
  // (0 = the accept cycle itself), and checks every cycle of it.
  task automatic do_txn(input string name, input bit we, input bit a0v,
                        input logic [7:0] wd, input logic [7:0] din,
                        input bit mid, input int mid_cyc, input logic [7:0] mid_d);
    logic [N-1:0] cs_e;
    logic [N+5:0] exp_v;
    logic [N+5:0] obs_v;
    bit a0_e, wr_e, rd_e, rv_e;
    cs_e = model_cs(we);
    a0_e = (!we && m_status) ? 1'b0 : a0v;
    req_valid = 1'b1;
    req_we    = we;
    req_a0    = a0v;
    req_wdata = wd;
    d_in      = din;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s ready_at_req: got %b expected 1", name, req_ready);
    end
    if (mid && mid_cyc == 0) begin
      cfg_wr = 1'b1;
      cfg_d  = mid_d;
    end
    @(posedge fclk); #1;
    req_valid = 1'b0;
    if (cfg_wr) begin
      cfg_wr = 1'b0;
      model_cfg(mid_d);
    end
    for (int j = 1; j <= T; j++) begin
      wr_e  = !(we && j > S && j <= S + P);
      rd_e  = !(!we && j > S && j <= S + P);
      rv_e  = !we && (j == S + P + 1);
      exp_v = {cs_e, wr_e, rd_e, we, a0_e, 1'b0, rv_e};
      obs_v = {cs_n, wr_n, rd_n, d_oe, a0, req_ready, rd_valid};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL %s pins cyc%0d {cs_n,wr_n,rd_n,d_oe,a0,ready,rd_valid}: got %b expected %b",
                 name, j, obs_v, exp_v);
      end
      if (we) begin
        vectors++;
        if (d_out !== wd) begin
          miscompares++;
          $display("[TB] FAIL %s d_out cyc%0d: got %h expected %h", name, j, d_out, wd);
        end
      end
      if (mid && mid_cyc == j) begin
        cfg_wr = 1'b1;
        cfg_d  = mid_d;
      end
      @(posedge fclk); #1;
      if (cfg_wr) begin
        cfg_wr = 1'b0;
        model_cfg(mid_d);
      end
    end
    exp_v = {{N{1'b1}}, 1'b1, 1'b1, 1'b0, a0, 1'b1, 1'b0};
    obs_v = {cs_n, wr_n, rd_n, d_oe, a0, req_ready, rd_valid};
    vectors++;
    if (obs_v !== exp_v || dac_en !== m_dac) begin
      miscompares++;
      $display("[TB] FAIL %s idle_after: got %b dac %b expected %b dac %b",
               name, obs_v, dac_en, exp_v, m_dac);
    end
    if (!we) begin
      vectors++;
      if (rd_data !== din) begin
        miscompares++;
        $display("[TB] FAIL %s rd_data: got %h expected %h", name, rd_data, din);
      end
    end
  endtask

  // Idle cycles with optional random config writes; bus must stay quiet.
  task automatic idle_cycles(input int n, input bit rand_cfg);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      vectors++;
      if ({cs_n, wr_n, rd_n, d_oe, req_ready, rd_valid, dac_en} !==
          {{N{1'b1}}, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, m_dac}) begin
        miscompares++;
        $display("[TB] FAIL idle: got cs_n %b wr_n %b rd_n %b d_oe %b ready %b rd_valid %b dac %b expected dac %b",
                 cs_n, wr_n, rd_n, d_oe, req_ready, rd_valid, dac_en, m_dac);
      end
      if (rand_cfg && $urandom_range(0, 1) == 1) begin
        r = 8'($urandom_range(0, 255));
        write_cfg(r);
      end else begin
        @(posedge fclk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge fclk);
    #1;
    model_reset();
    vectors++;
    if ({cs_n, rd_n, wr_n, a0, d_out, d_oe, rd_data, rd_valid, dac_en, req_ready} !==
        {{N{1'b1}}, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset: got cs_n %b rd_n %b wr_n %b a0 %b d_out %h d_oe %b rd_data %h rd_valid %b dac %b ready %b",
               cs_n, rd_n, wr_n, a0, d_out, d_oe, rd_data, rd_valid, dac_en, req_ready);
    end
    rst_n = 1'b1;
    @(posedge fclk); #1;
  endtask

  task automatic test_write_basic();
    write_cfg(8'h01);
    do_txn("write_chip1", 1'b1, 1'b1, 8'h5A, 8'h00, 1'b0, 0, 8'h00);
  endtask

  task automatic test_status_read();
    write_cfg(8'h04);
    do_txn("status_read", 1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 0, 8'h00);
    write_cfg(8'h00);
    do_txn("plain_read", 1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 0, 8'h00);
  endtask

  task automatic test_cfg_index();
    write_cfg(8'h01);
    write_cfg(8'h03);
    do_txn("bad_index_kept", 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 8'h00);
    write_cfg(8'h08);
    do_txn("dac_on_chip0", 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 0, 8'h00);
  endtask

  task automatic test_mid_cfg();
    write_cfg(8'h01);
    do_txn("mid_cfg_write", 1'b1, 1'b1, 8'h77, 8'h00, 1'b1, 3, 8'h00);
    do_txn("after_mid_cfg", 1'b1, 1'b0, 8'h88, 8'h00, 1'b0, 0, 8'h00);
  endtask

  task automatic test_same_cycle_cfg();
    write_cfg(8'h00);
    do_txn("same_cycle_cfg", 1'b0, 1'b1, 8'h00, 8'h96, 1'b1, 0, 8'h05);
    do_txn("next_after_same", 1'b0, 1'b1, 8'h00, 8'h69, 1'b0, 0, 8'h00);
  endtask

  task automatic test_broadcast();
    write_cfg(8'h10);
    do_txn("bcast_write", 1'b1, 1'b1, 8'hE1, 8'h00, 1'b0, 0, 8'h00);
    do_txn("bcast_read", 1'b0, 1'b1, 8'h00, 8'h1E, 1'b0, 0, 8'h00);
  endtask

  task automatic test_reset_abort();
    bit saw_valid;
    write_cfg(8'h01);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_a0    = 1'b1;
    d_in      = 8'hB4;
    @(posedge fclk); #1;
    req_valid = 1'b0;
    repeat (S + 1) @(posedge fclk);
    #1;
    vectors++;
    if (rd_n !== 1'b0 || cs_n !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL abort_in_strobe: got rd_n %b cs_n %b expected 0 01", rd_n, cs_n);
    end
    rst_n = 1'b0;
    @(posedge fclk); #1;
    rst_n = 1'b1;
    model_reset();
    vectors++;
    if ({cs_n, rd_n, wr_n, rd_valid, rd_data, dac_en} !== {2'b11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL abort_reset: got cs_n %b rd_n %b wr_n %b rd_valid %b rd_data %h dac %b",
               cs_n, rd_n, wr_n, rd_valid, rd_data, dac_en);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (rd_valid !== 1'b0 || cs_n !== 2'b11) saw_valid = 1'b1;
      @(posedge fclk); #1;
    end
    vectors++;
    if (saw_valid) begin
      miscompares++;
      $display("[TB] FAIL abort_quiet: got rd_valid/cs_n activity expected none");
    end
  endtask

  task automatic test_random();
    bit we, a0v, mid;
    int mc;
    logic [7:0] wd, din, md;
    for (int k = 0; k < 25; k++) begin
      idle_cycles($urandom_range(0, 3), 1'b1);
      we  = 1'($urandom_range(0, 1));
      a0v = 1'($urandom_range(0, 1));
      wd  = 8'($urandom_range(0, 255));
      din = 8'($urandom_range(0, 255));
      mid = ($urandom_range(0, 2) == 0);
      mc  = $urandom_range(0, T);
      md  = 8'($urandom_range(0, 255));
      do_txn("random", we, a0v, wd, din, mid, mc, md);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_a0      = 1'b0;
    req_wdata   = 8'h00;
    cfg_wr      = 1'b0;
    cfg_d       = 8'h00;
    d_in        = 8'h00;
    model_reset();

    test_reset();
    test_write_basic();
    test_status_read();
    test_cfg_index();
    test_mid_cfg();
    test_same_cycle_cfg();
    test_broadcast();
    test_reset_abort();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
